sonar_meas_sched: RTL and testbench

Measurement scheduler for the ultrasonic ranging path. It fires an HC-SR04 driver at a fixed period and waits for its result or a timeout. It converts the echo width into centimetres and streams an ASCII report line, byte by byte, into the UART transmitter over a valid/ready handshake. It sits between the ranging driver and the UART byte transmitter, in place of a direct data wire.

---
 rtl/sonar_sched_pkg.sv | 59 +++++
 rtl/bin2dec4.sv | 82 ++++++++
 rtl/sonar_meas_sched.sv | 194 +++++++++++++++++++
 tb/tb_sonar_meas_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_sched_pkg.sv
// Shared definitions for the sonar measurement scheduler.
// Holds the scheduler state encoding, the echo-to-centimetre divisor, the ASCII
// characters used in report lines, the two message lengths, and a helper that
// returns the report byte at a given position.
package sonar_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWait,
    StDiv,
    StBcd,
    StSend
  } sched_state_e;

  // Round-trip echo time per centimetre of range, in microseconds.
  localparam int unsigned US_PER_CM = 58;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_C  = 8'h63;
  localparam logic [7:0] CH_M  = 8'h6D;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam int unsigned MSG_LEN_NORM = 8;
  localparam int unsigned MSG_LEN_ERR  = 5;

  // Report byte at position idx. digits packs thousands in [15:12] down to units in [3:0].
  function automatic logic [7:0] msg_byte(input logic        is_err,
                                          input logic [15:0] digits,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    b = CH_LF;
    if (is_err) begin
      case (idx)
        3'd0:    b = CH_E;
        3'd1:    b = CH_R;
        3'd2:    b = CH_R;
        3'd3:    b = CH_CR;
        default: b = CH_LF;
      endcase
    end else begin
      case (idx)
        3'd0:    b = CH_0 + {4'h0, digits[15:12]};
        3'd1:    b = CH_0 + {4'h0, digits[11:8]};
        3'd2:    b = CH_0 + {4'h0, digits[7:4]};
        3'd3:    b = CH_0 + {4'h0, digits[3:0]};
        3'd4:    b = CH_C;
        3'd5:    b = CH_M;
        3'd6:    b = CH_CR;
        default: b = CH_LF;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2dec4.sv
// Sequential 11-bit binary to 4-digit BCD converter.
// A start pulse loads bin_i; each following cycle subtracts the largest of
// 1000/100/10 that still fits and bumps that digit. When the remainder drops
// below 10 it becomes the units digit and done_o pulses for one cycle.
// digits_o stays valid until the next start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      load bin_i and begin conversion (ignored state is overwritten)
//   bin_i        11-bit value to convert
//   done_o       one-cycle pulse, digits_o valid from this cycle on
//   digits_o     {thousands, hundreds, tens, units}, 4 bits each
module bin2dec4
  import sonar_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [10:0] bin_i,
  output logic        done_o,
  output logic [15:0] digits_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [10:0] val_q, val_d;
  logic [3:0]  th_q, th_d;
  logic [3:0]  hu_q, hu_d;
  logic [3:0]  te_q, te_d;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    val_d  = val_q;
    th_d   = th_q;
    hu_d   = hu_q;
    te_d   = te_q;
    if (start_i) begin
      busy_d = 1'b1;
      val_d  = bin_i;
      th_d   = 4'd0;
      hu_d   = 4'd0;
      te_d   = 4'd0;
    end else if (busy_q) begin
      if (val_q >= 11'd1000) begin
        val_d = val_q - 11'd1000;
        th_d  = th_q + 4'd1;
      end else if (val_q >= 11'd100) begin
        val_d = val_q - 11'd100;
        hu_d  = hu_q + 4'd1;
      end else if (val_q >= 11'd10) begin
        val_d = val_q - 11'd10;
        te_d  = te_q + 4'd1;
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      val_q  <= '0;
      th_q   <= '0;
      hu_q   <= '0;
      te_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      val_q  <= val_d;
      th_q   <= th_d;
      hu_q   <= hu_d;
      te_q   <= te_d;
    end
  end

  assign done_o   = done_q;
  // Remainder is below 10 once conversion finishes, so its low nibble is the units digit.
  assign digits_o = {th_q, hu_q, te_q, val_q[3:0]};

endmodule

// File: rtl/sonar_meas_sched.sv
// Sonar measurement scheduler.
// Fires the ranging driver once per period, waits for its echo width or a
// timeout, converts the width to centimetres (divide by 58, then BCD), and
// streams an ASCII report line to the UART over valid/ready.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   meas_start_o   one-cycle trigger pulse to the driver (registered)
//   meas_done_i    one-cycle result strobe; meas_data_i valid with it
//   meas_data_i    echo high time in microseconds
//   tx_data_o      report byte (registered, held while stalled)
//   tx_valid_o     tx_data_o valid (registered, independent of tx_ready_i)
//   tx_ready_i     UART accepts the byte
//   busy_o         scheduler not idle
//   overrun_o      one-cycle pulse when a period tick is dropped (registered)
//   err_cnt_o      saturating timeout count
module sonar_meas_sched
  import sonar_sched_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned PERIOD_MS  = 100,
  parameter int unsigned TIMEOUT_US = 30000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        meas_start_o,
  input  logic        meas_done_i,
  input  logic [15:0] meas_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned PERIOD_CYC  = CLK_FRE * 1000 * PERIOD_MS;
  localparam int unsigned TIMEOUT_CYC = CLK_FRE * TIMEOUT_US;
  localparam int unsigned PER_W       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_e state_q, state_d;

  logic [PER_W-1:0] period_q, period_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [15:0]      rem_q, rem_d;
  logic [10:0]      quot_q, quot_d;
  logic [2:0]       idx_q, idx_d;
  logic             is_err_q, is_err_d;
  logic             meas_start_q, meas_start_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic        tick;
  logic        bcd_start;
  logic        bcd_done;
  logic [15:0] bcd_digits;
  logic [2:0]  last_idx;

  // Free-running period counter; it never pauses, so skipped ticks do not shift the schedule.
  assign tick     = (period_q == PER_W'(PERIOD_CYC - 1));
  assign period_d = tick ? '0 : period_q + 1'b1;

  assign last_idx = is_err_q ? 3'(MSG_LEN_ERR - 1) : 3'(MSG_LEN_NORM - 1);

  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    idx_d        = idx_q;
    is_err_d     = is_err_q;
    meas_start_d = 1'b0;
    overrun_d    = tick && (state_q != StIdle);
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    err_cnt_d    = err_cnt_q;
    bcd_start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          // Raised on entry so the pulse is registered and coincides with TRIG.
          meas_start_d = 1'b1;
          state_d      = StTrig;
        end
      end

      StTrig: begin
        to_d    = '0;
        state_d = StWait;
      end

      StWait: begin
        if (meas_done_i) begin
          rem_d    = meas_data_i;
          quot_d   = '0;
          is_err_d = 1'b0;
          state_d  = StDiv;
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          is_err_d   = 1'b1;
          err_cnt_d  = (err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
          idx_d      = 3'd0;
          tx_data_d  = msg_byte(1'b1, bcd_digits, 3'd0);
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      StDiv: begin
        if (rem_q >= 16'(US_PER_CM)) begin
          rem_d  = rem_q - 16'(US_PER_CM);
          quot_d = quot_q + 11'd1;
        end else begin
          bcd_start = 1'b1;
          state_d   = StBcd;
        end
      end

      StBcd: begin
        if (bcd_done) begin
          idx_d      = 3'd0;
          tx_data_d  = msg_byte(1'b0, bcd_digits, 3'd0);
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end
      end

      StSend: begin
        if (tx_valid_q && tx_ready_i) begin
          if (idx_q == last_idx) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = msg_byte(is_err_q, bcd_digits, idx_q + 3'd1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      period_q     <= '0;
      to_q         <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      idx_q        <= '0;
      is_err_q     <= 1'b0;
      meas_start_q <= 1'b0;
      overrun_q    <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      to_q         <= to_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      idx_q        <= idx_d;
      is_err_q     <= is_err_d;
      meas_start_q <= meas_start_d;
      overrun_q    <= overrun_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  bin2dec4 u_bin2dec4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (bcd_start),
    .bin_i    (quot_q),
    .done_o   (bcd_done),
    .digits_o (bcd_digits)
  );

  assign meas_start_o = meas_start_q;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign overrun_o    = overrun_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_sonar_meas_sched.sv
// Bench for sonar_meas_sched with a 1000-cycle period and 100-cycle timeout.
// Expected report bytes are queued when a measurement reply is driven and
// compared as the DUT hands them over.
module tb_sonar_meas_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_start;
  logic        meas_done = 1'b0;
  logic [15:0] meas_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        overrun;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  sonar_meas_sched #(
    .CLK_FRE    (1),
    .PERIOD_MS  (1),
    .TIMEOUT_US (100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .meas_start_o (meas_start),
    .meas_done_i  (meas_done),
    .meas_data_i  (meas_data),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .err_cnt_o    (err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] sb_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte monitor: pops the scoreboard on every transfer and checks stall holding.
  always @(negedge clk) begin
    if (rst_n) begin
      if (meas_start) start_cnt++;
      if (overrun) ovr_cnt++;
      if (prev_stall) check_eq("hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (sb_q.size() == 0) check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        else check_eq("tx_byte", {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_num(input int data);
    int cm;
    cm = data / 58;
    sb_q.push_back(8'h30 + 8'(cm / 1000));
    sb_q.push_back(8'h30 + 8'((cm / 100) % 10));
    sb_q.push_back(8'h30 + 8'((cm / 10) % 10));
    sb_q.push_back(8'h30 + 8'(cm % 10));
    sb_q.push_back(8'h63);
    sb_q.push_back(8'h6D);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
  endtask

  task automatic push_err();
    sb_q.push_back(8'h45);
    sb_q.push_back(8'h52);
    sb_q.push_back(8'h52);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
  endtask

  // Returns at the negedge of the cycle where meas_start is high; cyc counts posedges.
  task automatic wait_start(output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (meas_start) return;
      if (cyc > 3000) begin
        check_eq("start_bound", 32'(cyc), 32'd3000);
        return;
      end
    end
  endtask

  // meas_done is high during the k-th cycle after the meas_start cycle.
  task automatic respond(input int k, input logic [15:0] data);
    repeat (k) @(posedge clk);
    #1;
    meas_done = 1'b1;
    meas_data = data;
    @(posedge clk);
    #1;
    meas_done = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 1300);
    if (!tx_valid) check_eq("valid_bound", 32'(n), 32'd1300);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb_q.size() != 0 || tx_valid) && n < 3000);
    check_eq("drained", {31'd0, tx_valid}, 32'd0);
    check_eq("sb_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lat;
    int s0;
    int o0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_meas_start", {31'd0, meas_start}, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    wait_start(cyc);
    check_eq("first_start", 32'(cyc), 32'd1000);

    // 1160 us -> 20 cm, eight back-to-back bytes
    push_num(1160);
    respond(5, 16'd1160);
    wait_valid();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check_eq("consec_valid", {31'd0, tx_valid}, 32'd1);
    end
    @(negedge clk);
    check_eq("valid_fall", {31'd0, tx_valid}, 32'd0);
    check_eq("idle_after", {31'd0, busy}, 32'd0);
    check_eq("sb_after_1160", 32'(sb_q.size()), 32'd0);

    // Largest echo, with latency bound
    wait_start(cyc);
    push_num(65535);
    repeat (3) @(posedge clk);
    #1;
    meas_done = 1'b1;
    meas_data = 16'hFFFF;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      meas_done = 1'b0;
      lat++;
    end while (!tx_valid && lat < 1300);
    check_eq("latency_le_1150", {31'd0, (lat <= 1150)}, 32'd1);
    wait_drain();

    // Just below one centimetre
    wait_start(cyc);
    push_num(57);
    respond(4, 16'd57);
    wait_drain();

    // meas_done while idle must be ignored
    respond(2, 16'd116);
    repeat (20) @(negedge clk);
    check_eq("ignore_busy", {31'd0, busy}, 32'd0);
    check_eq("ignore_valid", {31'd0, tx_valid}, 32'd0);

    // Timeout: ERR line, first byte valid one cycle after the timeout cycle
    wait_start(cyc);
    push_err();
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!tx_valid && cyc < 300);
    check_eq("timeout_cycle", 32'(cyc), 32'd101);
    wait_drain();
    check_eq("err_cnt_1", {24'd0, err_cnt}, 32'd1);

    // meas_done in the exact timeout cycle wins
    wait_start(cyc);
    push_num(580);
    respond(100, 16'd580);
    wait_drain();
    check_eq("err_cnt_kept", {24'd0, err_cnt}, 32'd1);

    // Saturation: preload just below the ceiling
    force dut.err_cnt_q = 8'd254;
    @(posedge clk);
    @(negedge clk);
    release dut.err_cnt_q;
    wait_start(cyc);
    push_err();
    wait_drain();
    check_eq("err_cnt_255", {24'd0, err_cnt}, 32'd255);
    wait_start(cyc);
    push_err();
    wait_drain();
    check_eq("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Long stall mid-message
    wait_start(cyc);
    push_num(3480);
    respond(5, 16'd3480);
    wait_valid();
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    s0 = start_cnt;
    o0 = ovr_cnt;
    repeat (2000) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_drain();
    check_eq("stall_overrun", {31'd0, (ovr_cnt > o0)}, 32'd1);
    check_eq("stall_no_start", 32'(start_cnt), 32'(s0));

    // Asynchronous reset during the third byte
    wait_start(cyc);
    push_num(1160);
    respond(5, 16'd1160);
    wait_valid();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("arst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("arst_meas_start", {31'd0, meas_start}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(cyc);
    check_eq("restart_start", 32'(cyc), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
